sdr_tx_scheduler: RTL and testbench

- Arbitrates access to the single UDP transmit path among all packet sources: discovery/programming responses, C&C, mic, wideband and the NR DDC streams.
- Owns the udp_tx_request/udp_tx_enable/udp_tx_active handshake with the MAC.
- Presents the winning source's length and port_ID, counts payload bytes, and tells the source when its packet starts and ends.
- Sits between the per-stream packet formatters and the UDP/IP transmit engine, replacing distributed priority logic.

---
 rtl/sdr_tx_scheduler_if.sv | 36 +++
 rtl/sdr_tx_scheduler.sv | 135 +++++++++++++
 tb/tb_sdr_tx_scheduler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdr_tx_scheduler_if.sv
// Transmit scheduler bus: per-source requests, grant signals and MAC handshake.
// Ports: run/req/req_length/req_port, udp_tx_* handshake, grant/byte_no status.
interface sdr_tx_scheduler_if #(
    parameter int NREQ = 12
);
    logic                   run;
    logic [NREQ-1:0]        req;
    logic [16*NREQ-1:0]     req_length;
    logic [8*NREQ-1:0]      req_port;
    logic                   udp_tx_enable;
    logic                   udp_tx_active;
    logic                   udp_tx_request;
    logic [15:0]            udp_tx_length;
    logic [7:0]             port_ID;
    logic [NREQ-1:0]        grant;
    logic                   grant_start;
    logic                   grant_done;
    logic [15:0]            byte_no;
    logic                   timeout_err;

    // scheduler side
    modport master (
        input  run, req, req_length, req_port,
        input  udp_tx_enable, udp_tx_active,
        output udp_tx_request, udp_tx_length, port_ID,
        output grant, grant_start, grant_done, byte_no, timeout_err
    );

    // sources and MAC side
    modport slave (
        output run, req, req_length, req_port,
        output udp_tx_enable, udp_tx_active,
        input  udp_tx_request, udp_tx_length, port_ID,
        input  grant, grant_start, grant_done, byte_no, timeout_err
    );
endinterface

// File: rtl/sdr_tx_scheduler.sv
// Single UDP transmit path arbiter: fixed priority for the low sources,
// round-robin for DDCs. Ports: tx_clock, reset_n, bus (master modport).
module sdr_tx_scheduler #(
    parameter int NREQ           = 12,
    parameter int NPRI           = 4,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic              tx_clock,
    input  logic              reset_n,
    sdr_tx_scheduler_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        ACTIVE
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   win;
    logic [WW-1:0]   wd;
    logic [NREQ-1:0] elig;
    logic            pick_ok;
    logic [IW-1:0]   pick;
    int              idx;
    logic            last_byte;
    logic            wd_exp;
    logic [IW-1:0]   rr_next;

    // Source 0 carries discovery/programming replies and runs while stopped.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = bus.req[i]
                && (bus.req_length[16*i +: 16] != 16'd0)
                && ((i == 0) || bus.run);
        end
    end

    // Both searches run high-to-low so the last hit is the preferred one.
    always_comb begin
        pick_ok = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int i = NPRI - 1; i >= 0; i--) begin
            if (elig[i]) begin
                pick_ok = 1'b1;
                pick    = IW'(i);
            end
        end
        if (!pick_ok) begin
            for (int k = NREQ - NPRI - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NREQ) begin
                    idx = idx - (NREQ - NPRI);
                end
                if (elig[idx]) begin
                    pick_ok = 1'b1;
                    pick    = IW'(idx);
                end
            end
        end
    end

    assign last_byte = bus.udp_tx_active
        && ((bus.byte_no + 16'd1) == bus.udp_tx_length);
    assign wd_exp  = (wd == WW'(TIMEOUT_CYCLES - 1));
    assign rr_next = (win == IW'(NREQ - 1)) ? IW'(NPRI) : win + 1'b1;

    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            rr_ptr             <= IW'(NPRI);
            win                <= '0;
            wd                 <= '0;
            bus.udp_tx_request <= 1'b0;
            bus.udp_tx_length  <= '0;
            bus.port_ID        <= '0;
            bus.grant          <= '0;
            bus.grant_start    <= 1'b0;
            bus.grant_done     <= 1'b0;
            bus.byte_no        <= '0;
            bus.timeout_err    <= 1'b0;
        end else begin
            bus.grant_start <= 1'b0;
            bus.grant_done  <= 1'b0;
            bus.timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    wd <= '0;
                    if (pick_ok) begin
                        state              <= REQUEST;
                        win                <= pick;
                        bus.udp_tx_request <= 1'b1;
                        bus.grant          <= NREQ'(1) << pick;
                        bus.udp_tx_length  <= bus.req_length[16*pick +: 16];
                        bus.port_ID        <= bus.req_port[8*pick +: 8];
                    end
                end
                REQUEST, ACTIVE: begin
                    wd <= wd + 1'b1;
                    // Completion wins over a watchdog expiry in the same cycle.
                    if ((state == ACTIVE && last_byte) || wd_exp) begin
                        state              <= IDLE;
                        wd                 <= '0;
                        bus.udp_tx_request <= 1'b0;
                        bus.grant          <= '0;
                        bus.byte_no        <= '0;
                        if (state == ACTIVE && last_byte) begin
                            bus.grant_done <= 1'b1;
                        end else begin
                            bus.timeout_err <= 1'b1;
                        end
                        if (win >= IW'(NPRI)) begin
                            rr_ptr <= rr_next;
                        end
                    end else if (state == REQUEST) begin
                        if (bus.udp_tx_enable) begin
                            state           <= ACTIVE;
                            bus.grant_start <= 1'b1;
                        end
                    end else if (bus.udp_tx_active) begin
                        bus.byte_no <= bus.byte_no + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdr_tx_scheduler.sv
// Bench for sdr_tx_scheduler: directed scenarios plus random packets,
// checked against a packet-level model of the arbitration rules.
module tb_sdr_tx_scheduler;
    localparam int NREQ = 12;
    localparam int NPRI = 4;
    localparam int TO   = 3000;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   rr;

    sdr_tx_scheduler_if #(.NREQ(NREQ)) bus ();

    sdr_tx_scheduler #(
        .NREQ(NREQ),
        .NPRI(NPRI),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .tx_clock(clk),
        .reset_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input int len, input int port);
        bus.req_length[16*i +: 16] = 16'(len);
        bus.req_port[8*i +: 8]     = 8'(port);
    endtask

    function automatic bit ok(input int i);
        return bus.req[i] && (bus.req_length[16*i +: 16] != 16'd0)
            && ((i == 0) || bus.run);
    endfunction

    // Fixed sources by index, then DDCs scanned circularly from rr.
    function automatic int model_winner();
        int n;
        n = NREQ - NPRI;
        for (int i = 0; i < NPRI; i++) begin
            if (ok(i)) return i;
        end
        for (int k = 0; k < n; k++) begin
            if (ok(NPRI + (rr - NPRI + k) % n)) return NPRI + (rr - NPRI + k) % n;
        end
        return -1;
    endfunction

    function automatic int rr_after(input int w);
        if (w < NPRI) return rr;
        return (w == NREQ - 1) ? NPRI : w + 1;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.udp_tx_enable = 1'b0;
        bus.udp_tx_active = 1'b0;
        bus.req = '0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        rr = NPRI;
    endtask

    task automatic do_packet(input int en_delay, input int act_pct,
                             input logic [31:0] pat, input int pat_n,
                             input bit drop);
        int w;
        int llen;
        int lport;
        int cnt;
        int cyc;
        bit a;
        w = model_winner();
        tick();
        chk("gap_done", 32'(bus.grant_done), 0);
        chk("gap_tmo", 32'(bus.timeout_err), 0);
        if (w < 0) begin
            chk("no_grant", 32'(bus.grant), 0);
            chk("no_req", 32'(bus.udp_tx_request), 0);
            return;
        end
        llen  = int'(bus.req_length[16*w +: 16]);
        lport = int'(bus.req_port[8*w +: 8]);
        chk("grant", 32'(bus.grant), 32'd1 << w);
        chk("tx_req", 32'(bus.udp_tx_request), 1);
        chk("tx_len", 32'(bus.udp_tx_length), 32'(llen));
        chk("port", 32'(bus.port_ID), 32'(lport));
        if (drop) begin
            bus.req[w] = 1'b0;
            set_src(w, $urandom_range(1, 65535), $urandom_range(0, 255));
        end
        repeat (en_delay) begin
            tick();
            chk("req_hold", 32'(bus.udp_tx_request), 1);
            chk("no_start", 32'(bus.grant_start), 0);
        end
        bus.udp_tx_enable = 1'b1;
        tick();
        bus.udp_tx_enable = 1'b0;
        chk("start", 32'(bus.grant_start), 1);
        chk("byte0", 32'(bus.byte_no), 0);
        cnt = 0;
        cyc = 0;
        while (cnt < llen) begin
            if (cyc >= 20000) begin
                chk("done_bound", 0, 1);
                break;
            end
            if (pat_n > 0) a = (cyc < pat_n) ? pat[cyc] : 1'b1;
            else a = ($urandom_range(0, 99) < act_pct);
            bus.udp_tx_active = a;
            if (a) cnt++;
            tick();
            cyc++;
            if (cnt == llen) begin
                chk("done", 32'(bus.grant_done), 1);
                chk("done_grant", 32'(bus.grant), 0);
                chk("done_req", 32'(bus.udp_tx_request), 0);
                chk("done_byte", 32'(bus.byte_no), 0);
            end else begin
                chk("byte_no", 32'(bus.byte_no), 32'(cnt));
                chk("early_done", 32'(bus.grant_done), 0);
                if (cyc == 1) chk("start_pulse", 32'(bus.grant_start), 0);
            end
        end
        bus.udp_tx_active = 1'b0;
        rr = rr_after(w);
    endtask

    initial begin
        int k;
        int w;
        n_chk  = 0;
        n_pass = 0;
        rr     = NPRI;
        rst_n  = 1'b0;
        bus.run = 1'b0;
        bus.req = '0;
        bus.req_length = '0;
        bus.req_port = '0;
        bus.udp_tx_enable = 1'b0;
        bus.udp_tx_active = 1'b0;
        #12;
        chk("rst_req", 32'(bus.udp_tx_request), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_len", 32'(bus.udp_tx_length), 0);
        chk("rst_port", 32'(bus.port_ID), 0);
        chk("rst_byte", 32'(bus.byte_no), 0);
        chk("rst_flags", 32'({bus.grant_start, bus.grant_done, bus.timeout_err}), 0);
        rst_n = 1'b1;

        // single DDC, long packet
        bus.run = 1'b1;
        set_src(5, 1444, 16);
        bus.req[5] = 1'b1;
        do_packet(3, 100, 0, 0, 1'b1);

        // priority then round-robin wrap
        do_reset();
        bus.run = 1'b1;
        set_src(1, 5, 1);
        set_src(4, 7, 4);
        set_src(6, 3, 6);
        set_src(7, 9, 7);
        bus.req[1] = 1'b1;
        bus.req[4] = 1'b1;
        bus.req[6] = 1'b1;
        bus.req[7] = 1'b1;
        do_packet(1, 100, 0, 0, 1'b0);
        bus.req[1] = 1'b0;
        repeat (6) do_packet($urandom_range(0, 2), 70, 0, 0, 1'b0);

        // stopped: only responses
        do_reset();
        bus.run = 1'b0;
        set_src(0, 60, 2);
        set_src(2, 20, 3);
        bus.req[0] = 1'b1;
        bus.req[2] = 1'b1;
        do_packet(0, 100, 0, 0, 1'b0);
        bus.req[0] = 1'b0;
        repeat (4) do_packet(0, 100, 0, 0, 1'b0);
        bus.run = 1'b1;
        do_packet(0, 100, 0, 0, 1'b0);
        bus.req = '0;

        // gapped active stream
        set_src(8, 4, 8);
        bus.req[8] = 1'b1;
        do_packet(0, 100, 32'h59, 7, 1'b1);

        // zero-length request is never granted
        set_src(9, 0, 9);
        bus.req[9] = 1'b1;
        do_packet(0, 100, 0, 0, 1'b0);

        // watchdog on a DDC, rr must still advance
        do_reset();
        bus.run = 1'b1;
        set_src(9, 10, 9);
        set_src(10, 12, 10);
        bus.req[9] = 1'b1;
        bus.req[10] = 1'b1;
        w = model_winner();
        tick();
        chk("wd_grant", 32'(bus.grant), 32'd1 << w);
        k = 0;
        while (1) begin
            tick();
            k++;
            if (bus.timeout_err) break;
            if (k > TO + 5) begin
                chk("wd_bound", 0, 1);
                break;
            end
        end
        chk("wd_cycle", 32'(k), 32'(TO));
        chk("wd_req", 32'(bus.udp_tx_request), 0);
        chk("wd_grant0", 32'(bus.grant), 0);
        rr = rr_after(w);
        do_packet(1, 100, 0, 0, 1'b0);
        bus.req = '0;

        // asynchronous reset mid-packet
        set_src(6, 1000, 6);
        set_src(11, 1000, 11);
        bus.req[6] = 1'b1;
        bus.req[11] = 1'b1;
        w = model_winner();
        tick();
        chk("pre_rst_grant", 32'(bus.grant), 32'd1 << w);
        bus.udp_tx_enable = 1'b1;
        tick();
        bus.udp_tx_enable = 1'b0;
        bus.udp_tx_active = 1'b1;
        repeat (500) tick();
        chk("pre_rst_byte", 32'(bus.byte_no), 500);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.udp_tx_request), 0);
        chk("arst_grant", 32'(bus.grant), 0);
        chk("arst_byte", 32'(bus.byte_no), 0);
        chk("arst_len", 32'(bus.udp_tx_length), 0);
        chk("arst_port", 32'(bus.port_ID), 0);
        bus.udp_tx_active = 1'b0;
        #2;
        rst_n = 1'b1;
        rr = NPRI;
        do_packet(2, 100, 0, 0, 1'b0);
        do_packet(0, 100, 0, 0, 1'b0);
        bus.req = '0;

        // random traffic
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                bus.req[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) set_src(i, 0, $urandom_range(0, 255));
                else set_src(i, $urandom_range(1, 40), $urandom_range(0, 255));
            end
            bus.run = ($urandom_range(0, 3) != 0);
            do_packet($urandom_range(0, 3), $urandom_range(40, 100), 0, 0,
                      1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
